seq_bit_serializer: RTL

SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

---
 rtl/seq_pkg.sv | 28 ++
 rtl/seq_shift_reg.sv | 42 ++++
 rtl/seq_bit_serializer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector slice.
//   ser_state_t : serializer FSM states (IDLE/SHIFT/PARITY)
//   det_state_t : downstream 1011 detector state constants
//   cnt_width() : bit-counter width for a WIDTH-bit word, ceil(log2(WIDTH+1))
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  typedef enum logic [2:0] {
    DET_S0    = 3'd0,
    DET_S1    = 3'd1,
    DET_S10   = 3'd2,
    DET_S101  = 3'd3,
    DET_S1011 = 3'd4
  } det_state_t;

  localparam det_state_t DET_RESET = DET_S0;

  // Wide enough to hold WIDTH itself, so the counter never wraps inside a word.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load shift register feeding the serial output.
//   clk, rst : clock, async active-high reset (clears the register)
//   clr      : synchronous clear (highest priority)
//   load     : load data
//   shift    : shift one position toward the head, inserting fill
//   fill     : bit shifted in at the tail
//   data     : parallel word
//   head     : bit currently at the output end (MSB or LSB per MSB_FIRST)
module seq_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic             fill,
  input  logic [WIDTH-1:0] data,
  output logic             head
);

  logic [WIDTH-1:0] q, q_sh;

  generate
    if (MSB_FIRST) begin : g_msb
      assign q_sh = {q[WIDTH-2:0], fill};
      assign head = q[WIDTH-1];
    end else begin : g_lsb
      assign q_sh = {fill, q[WIDTH-1:1]};
      assign head = q[0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (clr)   q <= '0;
    else if (load)  q <= data;
    else if (shift) q <= q_sh;
  end

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial converter driving a sequence detector's j input.
//   clk, rst  : clock, async active-high reset
//   in_data   : word to serialize, sampled on acceptance (in_valid & in_ready)
//   in_valid  : in_data valid
//   in_ready  : word can be accepted this cycle (state/counter only)
//   j         : serial bit, 0 whenever idle
//   j_valid   : j carries a payload or parity bit
//   busy      : state != IDLE
// Build option: define SEQ_SER_PARITY_EN to append an even-parity bit per word.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             j,
  output logic             j_valid,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  ser_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          load, shift, clr, rdy, fill, last;

  assign last = (cnt == CW'(WIDTH - 1));

  // j comes straight off the shift register head. The register is cleared on
  // the way back to IDLE so j reads 0 between words.
  seq_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .load  (load),
    .shift (shift),
    .fill  (fill),
    .data  (in_data),
    .head  (j)
  );

`ifdef SEQ_SER_PARITY_EN
  // The first fill bit reaches the head after exactly WIDTH shifts, i.e. in
  // the PARITY cycle, so filling with the word's parity emits it for free.
  logic par_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       par_q <= 1'b0;
    else if (load) par_q <= ^in_data;
  end
  assign fill = par_q;
`else
  assign fill = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    shift    = 1'b0;
    clr      = 1'b0;
    rdy      = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (in_valid) begin
          load     = 1'b1;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
`ifdef SEQ_SER_PARITY_EN
        shift  = 1'b1;
        cnt_nx = cnt + CW'(1);
        if (last) state_nx = PARITY;
`else
        if (last) begin
          rdy = 1'b1;
          if (in_valid) begin
            load   = 1'b1;
            cnt_nx = '0;
          end else begin
            clr      = 1'b1;
            state_nx = IDLE;
          end
        end else begin
          shift  = 1'b1;
          cnt_nx = cnt + CW'(1);
        end
`endif
      end
`ifdef SEQ_SER_PARITY_EN
      PARITY: begin
        rdy = 1'b1;
        if (in_valid) begin
          load     = 1'b1;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end else begin
          clr      = 1'b1;
          state_nx = IDLE;
        end
      end
`endif
      default: begin
        clr      = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      j_valid <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      j_valid <= (state_nx != IDLE);
    end
  end

  // Reset gating keeps in_ready low while rst is asserted.
  assign in_ready = rdy & ~rst;
  assign busy     = (state != IDLE);

endmodule
